// File: rtl/fifo_memoria_umbrales_if.sv
// Handshake/data bundle between a producer/consumer pair and the thresholded FIFO.
// The master modport is the user side; the slave modport is the FIFO itself.
interface fifo_memoria_umbrales_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] FIFO_data_in;
    logic [ADDR_WIDTH:0]   umbral_alto;
    logic [ADDR_WIDTH:0]   umbral_bajo;
    logic [DATA_WIDTH-1:0] FIFO_data_out;
    logic                  valid_out;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   fifo_count;
    logic                  error_overflow;
    logic                  error_underflow;

    modport master (
        output write_enable, read_enable, FIFO_data_in, umbral_alto, umbral_bajo,
        input  FIFO_data_out, valid_out, fifo_full, fifo_empty, almost_full,
               almost_empty, fifo_count, error_overflow, error_underflow
    );

    modport slave (
        input  write_enable, read_enable, FIFO_data_in, umbral_alto, umbral_bajo,
        output FIFO_data_out, valid_out, fifo_full, fifo_empty, almost_full,
               almost_empty, fifo_count, error_overflow, error_underflow
    );
endinterface

// File: rtl/fifo_memoria_umbrales.sv
// Synchronous FIFO with internally owned pointers, occupancy counter,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Full/empty come from the occupancy counter, never from pointer equality,
// so the pointers can wrap freely at 2**ADDR_WIDTH.
module fifo_memoria_umbrales #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_L,
    fifo_memoria_umbrales_if.slave   bus
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_0   = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0] COUNT_1   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_0   = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_1   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_0  = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_next_s;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_r;
    logic                  err_ovf_r;
    logic                  err_unf_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  rd_ok_s;
    logic                  wr_ok_s;

    // Status flags and accept decisions, all derived from the registered count.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == COUNT_0);
        // A read into an empty FIFO is rejected even when a write lands in the same cycle.
        rd_ok_s = bus.read_enable && !empty_s;
        // When full, a write is still accepted if a read frees a slot on the same edge.
        wr_ok_s = bus.write_enable && (!full_s || rd_ok_s);
    end

    // Occupancy update: simultaneous accepted read and write leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_next_s = count_r + COUNT_1;
            2'b01:   count_next_s = count_r - COUNT_1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage array: written on accepted writes only, contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= bus.FIFO_data_in;
        end
    end

    // Pointers, counter, registered read port and sticky error flags.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_r   <= PTR_0;
            rd_ptr_r   <= PTR_0;
            count_r    <= COUNT_0;
            data_out_r <= DATA_0;
            valid_r    <= 1'b0;
            err_ovf_r  <= 1'b0;
            err_unf_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            valid_r <= rd_ok_s;
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_1;
            end
            if (rd_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_1;
                data_out_r <= mem_r[rd_ptr_r];
            end
            // Dropped write: full and no read making room on this edge.
            if (bus.write_enable && full_s && !rd_ok_s) begin
                err_ovf_r <= 1'b1;
            end
            if (bus.read_enable && empty_s) begin
                err_unf_r <= 1'b1;
            end
        end
    end

    assign bus.FIFO_data_out   = data_out_r;
    assign bus.valid_out       = valid_r;
    assign bus.fifo_full       = full_s;
    assign bus.fifo_empty      = empty_s;
    // Thresholds are live inputs; these flags follow them in the same cycle.
    assign bus.almost_full     = (count_r >= bus.umbral_alto);
    assign bus.almost_empty    = (count_r <= bus.umbral_bajo);
    assign bus.fifo_count      = count_r;
    assign bus.error_overflow  = err_ovf_r;
    assign bus.error_underflow = err_unf_r;
endmodule

// File: tb/tb_fifo_memoria_umbrales.sv
// Directed testbench for fifo_memoria_umbrales: linear sequence of steps,
// each check an immediate assertion against a hand-computed value.
module tb_fifo_memoria_umbrales;
    logic clk;
    logic reset_L;
    int   passed;
    int   total;

    fifo_memoria_umbrales_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    fifo_memoria_umbrales #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset_L = 1'b0;
        #1;
        reset_L = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] w;
        passed = 0;
        total  = 0;
        reset_L = 1'b0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.FIFO_data_in = 8'h00;
        bus.umbral_alto  = 4'd6;
        bus.umbral_bajo  = 4'd2;
        tick();
        tick();

        // Reset state
        check("rst_count", bus.fifo_count, 32'd0);
        check("rst_empty", bus.fifo_empty, 32'd1);
        check("rst_full", bus.fifo_full, 32'd0);
        check("rst_aempty", bus.almost_empty, 32'd1);
        check("rst_afull", bus.almost_full, 32'd0);
        check("rst_valid", bus.valid_out, 32'd0);
        check("rst_dout", bus.FIFO_data_out, 32'h0);
        check("rst_ovf", bus.error_overflow, 32'd0);
        check("rst_unf", bus.error_underflow, 32'd0);
        reset_L = 1'b1;

        // 1: three writes then three reads
        bus.write_enable = 1'b1;
        bus.FIFO_data_in = 8'hFF; tick();
        bus.FIFO_data_in = 8'hAF; tick();
        bus.FIFO_data_in = 8'h17; tick();
        bus.write_enable = 1'b0;
        check("t1_count", bus.fifo_count, 32'd3);
        check("t1_empty", bus.fifo_empty, 32'd0);
        check("t1_aempty", bus.almost_empty, 32'd0);
        bus.read_enable = 1'b1;
        tick();
        check("t1_d0", bus.FIFO_data_out, 32'hFF);
        check("t1_v0", bus.valid_out, 32'd1);
        tick();
        check("t1_d1", bus.FIFO_data_out, 32'hAF);
        check("t1_v1", bus.valid_out, 32'd1);
        tick();
        check("t1_d2", bus.FIFO_data_out, 32'h17);
        check("t1_v2", bus.valid_out, 32'd1);
        check("t1_empty_end", bus.fifo_empty, 32'd1);
        bus.read_enable = 1'b0;
        tick();
        check("t1_valid_low", bus.valid_out, 32'd0);
        check("t1_dout_hold", bus.FIFO_data_out, 32'h17);

        // 2: fill with thresholds 6/2, then overflow
        bus.write_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'h30 + 8'(i);
            bus.FIFO_data_in = w;
            tick();
            if (i == 1) check("t2_aempty_at2", bus.almost_empty, 32'd1);
            if (i == 4) check("t2_afull_at5", bus.almost_full, 32'd0);
            if (i == 5) check("t2_afull_at6", bus.almost_full, 32'd1);
            if (i == 6) check("t2_full_at7", bus.fifo_full, 32'd0);
        end
        check("t2_full", bus.fifo_full, 32'd1);
        check("t2_count8", bus.fifo_count, 32'd8);
        bus.umbral_alto = 4'd9;
        #1;
        check("t2_afull_thr9", bus.almost_full, 32'd0);
        bus.umbral_alto = 4'd6;
        #1;
        check("t2_afull_thr6", bus.almost_full, 32'd1);
        bus.FIFO_data_in = 8'h6A;
        tick();
        bus.write_enable = 1'b0;
        check("t2_ovf", bus.error_overflow, 32'd1);
        check("t2_count_hold", bus.fifo_count, 32'd8);
        bus.read_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            w = 8'h30 + 8'(i);
            check("t2_rd", bus.FIFO_data_out, 32'(w));
        end
        bus.read_enable = 1'b0;
        check("t2_empty", bus.fifo_empty, 32'd1);
        check("t2_ovf_sticky", bus.error_overflow, 32'd1);
        tick();
        check("t2_no_extra", bus.valid_out, 32'd0);

        // 3: full with simultaneous read and write
        pulse_reset();
        check("t3_ovf_cleared", bus.error_overflow, 32'd0);
        bus.write_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 8'h40 + 8'(i);
            bus.FIFO_data_in = w;
            tick();
        end
        bus.read_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 8'h50 + 8'(i);
            bus.FIFO_data_in = w;
            tick();
            w = 8'h40 + 8'(i);
            check("t3_rw_dout", bus.FIFO_data_out, 32'(w));
            check("t3_rw_count", bus.fifo_count, 32'd8);
        end
        bus.write_enable = 1'b0;
        check("t3_no_ovf", bus.error_overflow, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            w = (i < 4) ? 8'h44 + 8'(i) : 8'h50 + 8'(i - 4);
            check("t3_drain", bus.FIFO_data_out, 32'(w));
        end
        bus.read_enable = 1'b0;
        check("t3_empty", bus.fifo_empty, 32'd1);

        // 4: read+write into empty FIFO
        pulse_reset();
        bus.write_enable = 1'b1;
        bus.read_enable  = 1'b1;
        bus.FIFO_data_in = 8'hB8;
        tick();
        bus.write_enable = 1'b0;
        check("t4_valid", bus.valid_out, 32'd0);
        check("t4_count", bus.fifo_count, 32'd1);
        check("t4_unf", bus.error_underflow, 32'd1);
        tick();
        bus.read_enable = 1'b0;
        check("t4_dout", bus.FIFO_data_out, 32'hB8);
        check("t4_valid2", bus.valid_out, 32'd1);
        check("t4_empty", bus.fifo_empty, 32'd1);

        // 5: 20 words streamed, pointers wrap twice
        pulse_reset();
        for (int i = 0; i < 23; i++) begin
            w = 8'hA0 + 8'(i);
            bus.write_enable = (i < 20);
            bus.read_enable  = (i >= 3);
            bus.FIFO_data_in = w;
            tick();
            if (i >= 3) begin
                w = 8'hA0 + 8'(i - 3);
                check("t5_stream", bus.FIFO_data_out, 32'(w));
            end
            if (i == 10) check("t5_count_mid", bus.fifo_count, 32'd3);
        end
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        check("t5_count_end", bus.fifo_count, 32'd0);
        check("t5_ovf", bus.error_overflow, 32'd0);
        check("t5_unf", bus.error_underflow, 32'd0);

        // 6: asynchronous reset mid-operation
        bus.write_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = 8'hC0 + 8'(i);
            bus.FIFO_data_in = w;
            tick();
        end
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b1;
        tick();
        bus.read_enable  = 1'b0;
        check("t6_pre_dout", bus.FIFO_data_out, 32'hC0);
        check("t6_pre_count", bus.fifo_count, 32'd4);
        #2;
        reset_L = 1'b0;
        #1;
        check("t6_async_count", bus.fifo_count, 32'd0);
        check("t6_async_dout", bus.FIFO_data_out, 32'h0);
        check("t6_async_valid", bus.valid_out, 32'd0);
        check("t6_async_empty", bus.fifo_empty, 32'd1);
        reset_L = 1'b1;
        tick();
        bus.read_enable = 1'b1;
        tick();
        bus.read_enable = 1'b0;
        check("t6_unf", bus.error_underflow, 32'd1);
        check("t6_valid", bus.valid_out, 32'd0);
        check("t6_dout", bus.FIFO_data_out, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
